if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch buffer directly downstream of the PC generator and the synchronous instruction ROM.
- Captures each issued PC and pairs it with the ROM word returned one cycle later.
- Queues the {pc, inst} pairs in a small FIFO and presents them to the ID stage with a valid/ready handshake.
- Back-pressures the PC generator with a stall, and discards all buffered and in-flight fetches on a branch flush.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- AW, 32, instruction address width (InstAddrBus).
- DW, 32, instruction width (InstBus).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_i  in  AW  PC currently driven to the ROM by the PC generator.
- ce_i  in  1  ROM chip enable from the PC generator; 1 = pc_i is a real fetch.
- inst_i  in  DW  ROM read data; valid the cycle after its PC was presented.
- flush_i  in  1  branch/redirect; kills the queue and the in-flight fetch.
- stall_o  out  1  holds the PC generator; that PC is re-presented next cycle.
- id_pc_o  out  AW  PC of the head entry.
- id_inst_o  out  DW  instruction of the head entry.
- id_valid_o  out  1  head entry valid.
- id_ready_i  in  1  ID stage accepts the head this cycle.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.
- ovf_o  out  1  sticky: a push was attempted while full (protocol error).

Behaviour:
- Issue condition: issue = ce_i & ~stall_o & ~flush_i.
  - On each edge: pend_valid <= issue; pend_pc <= pc_i when issue.
- Push condition: push = pend_valid & ~flush_i.
  - The entry written is {pend_pc, inst_i}, with inst_i sampled in the cycle after issue.
- Pop condition: pop = id_valid_o & id_ready_i & ~flush_i.
- Latency: PC issued at edge N → entry written at edge N+1 → id_valid_o=1 during cycle N+2 (zero-bubble when the queue is empty).
- Queue: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus an explicit count register.
  - count is updated as count + push − pop.
  - id_pc_o/id_inst_o are read combinationally from mem[rd_ptr].
  - When empty: id_valid_o=0, id_pc_o=0, id_inst_o=0 (NOP).
- Stall: stall_o = (count + pend_valid) >= DEPTH. This is combinational and credit-based, so one slot is always reserved for the in-flight fetch.
- Simultaneous push and pop:
  - Allowed at any count, including full; count unchanged, both pointers advance.
- Full and push without pop:
  - The entry is dropped and ovf_o is set to 1.
  - ovf_o stays set until rst; this is unreachable when the PC generator honours stall_o.
- Flush:
  - On the edge where flush_i=1: count<=0, rd_ptr<=wr_ptr, pend_valid<=0.
  - Any same-cycle push, pop or issue is discarded; flush wins over everything.
  - From the cycle after flush, id_valid_o=0 and stall_o=0.
  - The first post-flush entry is the PC issued after the flush edge.
- Reset (any cycle, including mid-stream): count=0, pointers=0, pend_valid=0, ovf_o=0.
  - Resulting outputs: id_valid_o=0, id_pc_o=0, id_inst_o=0, stall_o=0.
  - Memory contents are don't-care and need not be cleared.
- ce_i=0 (the PC generator is still in reset): no issue; queue contents drain normally.
- Width rules: pointers wrap naturally with no special case; count_o range 0..DEPTH.

Decomposition:
- Shared defines header: InstAddrBus, InstBus, RstEnable, ChipEnable, plus a new Flush/NoFlush pair.
- One natural sub-module: fetch_fifo, a generic DEPTH x (AW+DW) synchronous FIFO with push/pop/clear, count and full/empty flags.
- Pend-stage logic, stall and ovf live in the top level.

Test Plan:
1. Reset then streaming: rst for 2 cycles, then ce_i=1, pc_i=0,4,8,…, id_ready_i=1, ROM returns inst=pc^32'hA5A5_0000.
   - First entry id_pc_o=0 with id_inst_o=32'hA5A5_0000 in cycle 2 after the first issue.
   - Then one entry per cycle; stall_o stays 0.
2. Back-pressure: id_ready_i=0 with a stream running.
   - stall_o rises when count+pend=4; count_o saturates at 4; ovf_o stays 0.
   - Raise ready: entries pop in order 0,4,8,12, then resume with no gaps or duplicates.
3. Flush with a full queue and pend_valid=1, flush_i pulsed with id_ready_i=1.
   - Next cycle: count_o=0, id_valid_o=0, stall_o=0.
   - After redirect pc_i=32'h100: the next delivered id_pc_o is 32'h100.
4. Simultaneous push and pop at count=4 (force ce_i, ignoring the stall): count_o stays 4, FIFO order is preserved, ovf_o=0.
5. Forced overflow: count=4, id_ready_i=0, inject pend_valid.
   - ovf_o=1 and count_o=4; the head is unchanged; ovf_o holds until rst.
6. Reset mid-stream with 3 entries queued: rst for 1 cycle.
   - Next cycle: count_o=0, id_valid_o=0, ovf_o=0.
   - The first post-reset fetch is delivered 2 cycles after its issue.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-path definitions: bus widths and control polarities.
package if_fetch_queue_pkg;
    localparam int   INST_ADDR_W = 32;  // InstAddrBus
    localparam int   INST_W      = 32;  // InstBus
    localparam logic RST_ENABLE  = 1'b1;
    localparam logic CHIP_ENABLE = 1'b1;
    localparam logic FLUSH       = 1'b1;
    localparam logic NO_FLUSH    = 1'b0;
endpackage

// File: rtl/if_fetch_queue_if.sv
// PC-generator / ROM / ID-stage bundle around the fetch queue.
interface if_fetch_queue_if
    import if_fetch_queue_pkg::*;
#(
    parameter int AW    = INST_ADDR_W,
    parameter int DW    = INST_W,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] pc_i;
    logic          ce_i;
    logic [DW-1:0] inst_i;
    logic          flush_i;
    logic          stall_o;
    logic [AW-1:0] id_pc_o;
    logic [DW-1:0] id_inst_o;
    logic          id_valid_o;
    logic          id_ready_i;
    logic [CW-1:0] count_o;
    logic          ovf_o;

    modport slave (
        input  pc_i, ce_i, inst_i, flush_i, id_ready_i,
        output stall_o, id_pc_o, id_inst_o, id_valid_o, count_o, ovf_o
    );

    modport master (
        output pc_i, ce_i, inst_i, flush_i, id_ready_i,
        input  stall_o, id_pc_o, id_inst_o, id_valid_o, count_o, ovf_o
    );
endinterface

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Generic DEPTH x W circular FIFO with explicit count; clear drops all entries.
module fetch_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [W-1:0]               i_wdata,
    output logic [W-1:0]               o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr_en;
    logic          w_rd_en;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign w_wr_en = i_push & (~o_full | i_pop) & ~i_clear;
    assign w_rd_en = i_pop & ~o_empty & ~i_clear;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/if_fetch_queue.sv
// Fetch buffer: pairs each issued PC with the ROM word of the next cycle and queues it for ID.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = INST_ADDR_W,
    parameter int DW    = INST_W
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_queue_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of two >= 2");
    end

    logic          r_pend_valid;
    logic [AW-1:0] r_pend_pc;
    logic          r_ovf;

    logic          w_flush;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_stall;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [AW+DW-1:0] w_rdata;

    assign w_flush = (bus.flush_i == FLUSH);

    // Credit-based: the in-flight fetch already owns a slot, so stall counts it.
    assign w_stall = (w_count + CW'(r_pend_valid)) >= CW'(DEPTH);
    assign w_issue = (bus.ce_i == CHIP_ENABLE) & ~w_stall & (bus.flush_i == NO_FLUSH);
    assign w_push  = r_pend_valid & ~w_flush;
    assign w_pop   = ~w_empty & bus.id_ready_i & ~w_flush;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_pend_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_pend_valid <= w_issue;
            if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) r_pend_pc <= bus.pc_i;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_flush),
        .i_wdata ({r_pend_pc, bus.inst_i}),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.stall_o    = w_stall;
    assign bus.id_valid_o = ~w_empty;
    assign bus.id_pc_o    = w_rdata[AW+DW-1:DW];
    assign bus.id_inst_o  = w_rdata[DW-1:0];
    assign bus.count_o    = w_count;
    assign bus.ovf_o      = r_ovf;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: vector table for streaming/back-pressure/flush, hand sequences for the rest.
module tb_if_fetch_queue;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.AW(32), .DW(32), .DEPTH(4)) bus ();

    if_fetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous ROM model: word for a PC appears the cycle after it is presented.
    always @(posedge clk) bus.inst_i <= bus.pc_i ^ KEY;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic        rdy;
        logic        fl;
        logic        vld;
        logic [31:0] epc;
        logic [2:0]  cnt;
        logic        stall;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic [31:0] pc, input logic rdy, input logic fl);
        bus.ce_i       = ce;
        bus.pc_i       = pc;
        bus.id_ready_i = rdy;
        bus.flush_i    = fl;
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic cyc_chk(input string tag, input logic vld, input logic [31:0] pc,
                           input logic [31:0] inst, input logic [2:0] cnt,
                           input logic stall, input logic ovf);
        @(negedge clk);
        chk($sformatf("%s.valid", tag), 32'(bus.id_valid_o), 32'(vld));
        chk($sformatf("%s.pc",    tag), bus.id_pc_o, pc);
        chk($sformatf("%s.inst",  tag), bus.id_inst_o, inst);
        chk($sformatf("%s.count", tag), 32'(bus.count_o), 32'(cnt));
        chk($sformatf("%s.stall", tag), 32'(bus.stall_o), 32'(stall));
        chk($sformatf("%s.ovf",   tag), 32'(bus.ovf_o), 32'(ovf));
        @(posedge clk);
        #1;
    endtask

    // Fill from empty with ready low: four issues land, the fifth PC is held by stall.
    task automatic fill(input string tag, input logic [31:0] b);
        drive(1'b1, b,         1'b0, 1'b0); cyc_chk({tag, ".f0"}, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        drive(1'b1, b + 32'h4, 1'b0, 1'b0); cyc_chk({tag, ".f1"}, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        drive(1'b1, b + 32'h8, 1'b0, 1'b0); cyc_chk({tag, ".f2"}, 1'b1, b, b ^ KEY, 3'd1, 1'b0, 1'b0);
        drive(1'b1, b + 32'hC, 1'b0, 1'b0); cyc_chk({tag, ".f3"}, 1'b1, b, b ^ KEY, 3'd2, 1'b0, 1'b0);
        drive(1'b1, b + 32'h10, 1'b0, 1'b0); cyc_chk({tag, ".f4"}, 1'b1, b, b ^ KEY, 3'd3, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] b;

        //               ce    pc        rdy   fl      vld   epc       cnt   stall
        tbl[0]  = '{1'b1, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 32'h004, 1'b1, 1'b0, 1'b0, 32'h000, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 32'h008, 1'b1, 1'b0, 1'b1, 32'h000, 3'd1, 1'b0};
        tbl[3]  = '{1'b1, 32'h00C, 1'b0, 1'b0, 1'b1, 32'h004, 3'd1, 1'b0};
        tbl[4]  = '{1'b1, 32'h010, 1'b0, 1'b0, 1'b1, 32'h004, 3'd2, 1'b0};
        tbl[5]  = '{1'b1, 32'h014, 1'b0, 1'b0, 1'b1, 32'h004, 3'd3, 1'b1};
        tbl[6]  = '{1'b1, 32'h014, 1'b0, 1'b0, 1'b1, 32'h004, 3'd4, 1'b1};
        tbl[7]  = '{1'b1, 32'h014, 1'b1, 1'b0, 1'b1, 32'h004, 3'd4, 1'b1};
        tbl[8]  = '{1'b1, 32'h014, 1'b1, 1'b0, 1'b1, 32'h008, 3'd3, 1'b0};
        tbl[9]  = '{1'b1, 32'h018, 1'b1, 1'b0, 1'b1, 32'h00C, 3'd2, 1'b0};
        tbl[10] = '{1'b1, 32'h01C, 1'b1, 1'b0, 1'b1, 32'h010, 3'd2, 1'b0};
        tbl[11] = '{1'b1, 32'h020, 1'b1, 1'b0, 1'b1, 32'h014, 3'd2, 1'b0};
        tbl[12] = '{1'b1, 32'h024, 1'b0, 1'b0, 1'b1, 32'h018, 3'd2, 1'b0};
        tbl[13] = '{1'b1, 32'h028, 1'b1, 1'b1, 1'b1, 32'h018, 3'd3, 1'b1};
        tbl[14] = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h000, 3'd0, 1'b0};
        tbl[15] = '{1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h000, 3'd0, 1'b0};
        tbl[16] = '{1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h100, 3'd1, 1'b0};
        tbl[17] = '{1'b0, 32'h10C, 1'b1, 1'b0, 1'b1, 32'h104, 3'd1, 1'b0};
        tbl[18] = '{1'b0, 32'h10C, 1'b1, 1'b0, 1'b1, 32'h108, 3'd1, 1'b0};
        tbl[19] = '{1'b0, 32'h10C, 1'b1, 1'b0, 1'b0, 32'h000, 3'd0, 1'b0};

        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cyc_chk("reset", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Streaming, back-pressure, flush with a redirect to 0x100, drain.
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].ce, tbl[i].pc, tbl[i].rdy, tbl[i].fl);
            cyc_chk($sformatf("vec%0d", i), tbl[i].vld, tbl[i].epc,
                    tbl[i].vld ? (tbl[i].epc ^ KEY) : 32'h0, tbl[i].cnt, tbl[i].stall, 1'b0);
        end

        // Push and pop together while full: an injected in-flight fetch joins the tail.
        b = 32'h200;
        fill("pp", b);
        drive(1'b0, b + 32'h10, 1'b1, 1'b0);
        force dut.r_pend_valid = 1'b1;
        cyc_chk("pp.a", 1'b1, b, b ^ KEY, 3'd4, 1'b1, 1'b0);
        force dut.r_pend_valid = 1'b0;
        cyc_chk("pp.b", 1'b1, b + 32'h4, (b + 32'h4) ^ KEY, 3'd4, 1'b1, 1'b0);
        release dut.r_pend_valid;
        cyc_chk("pp.c", 1'b1, b + 32'h8, (b + 32'h8) ^ KEY, 3'd3, 1'b0, 1'b0);
        cyc_chk("pp.d", 1'b1, b + 32'hC, (b + 32'hC) ^ KEY, 3'd2, 1'b0, 1'b0);
        cyc_chk("pp.e", 1'b1, b + 32'hC, (b + 32'h10) ^ KEY, 3'd1, 1'b0, 1'b0);
        cyc_chk("pp.f", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);

        // Overflow: push while full with no pop is dropped and latches ovf.
        b = 32'h300;
        fill("ov", b);
        drive(1'b0, b + 32'h10, 1'b0, 1'b0);
        force dut.r_pend_valid = 1'b1;
        cyc_chk("ov.a", 1'b1, b, b ^ KEY, 3'd4, 1'b1, 1'b0);
        force dut.r_pend_valid = 1'b0;
        drive(1'b0, b + 32'h10, 1'b1, 1'b0);
        cyc_chk("ov.b", 1'b1, b, b ^ KEY, 3'd4, 1'b1, 1'b1);
        release dut.r_pend_valid;
        drive(1'b0, b + 32'h10, 1'b0, 1'b0);
        cyc_chk("ov.c", 1'b1, b + 32'h4, (b + 32'h4) ^ KEY, 3'd3, 1'b0, 1'b1);

        // Reset mid-stream with three entries queued.
        rst = 1'b1;
        cyc_chk("rs.a", 1'b1, b + 32'h4, (b + 32'h4) ^ KEY, 3'd3, 1'b0, 1'b1);
        rst = 1'b0;
        drive(1'b1, 32'h400, 1'b1, 1'b0);
        cyc_chk("rs.b", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 32'h404, 1'b1, 1'b0);
        cyc_chk("rs.c", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        cyc_chk("rs.d", 1'b1, 32'h400, 32'h400 ^ KEY, 3'd1, 1'b0, 1'b0);
        cyc_chk("rs.e", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
